pipe_elastic: RTL and testbench

//  Generic elastic pipeline register; successor to the fixed-field D/A/M/W stage registers.

---
 rtl/pipe_elastic.sv | 114 +++++++++++
 tb/tb_pipe_elastic.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pipe_elastic.sv
// Elastic pipeline register: valid/ready on both sides, 2-entry skid buffer,
// flush-to-bubble, occupancy report and a saturating downstream stall counter.
module pipe_elastic #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_occupancy,
  output logic [CNT_WIDTH-1:0]  o_stall_cycles
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [DATA_WIDTH-1:0] w_main_nxt;
  logic [DATA_WIDTH-1:0] w_skid_nxt;
  logic                  r_ready;
  logic [CNT_WIDTH-1:0]  r_stall;
  logic                  w_valid;
  logic                  w_push;
  logic                  w_pop;

  assign w_valid = (r_state != S_EMPTY);
  assign w_push  = i_valid & r_ready;
  assign w_pop   = w_valid & i_ready;

  // Flush overrides the handshake but leaves data registers untouched.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (i_flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = i_data;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            w_main_nxt  = i_data;
          end else if (w_push) begin
            w_state_nxt = S_FULL;
            w_skid_nxt  = i_data;
          end else if (w_pop) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // o_ready is registered from the next state, so i_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_ready <= 1'b1;
      r_stall <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      r_ready <= (w_state_nxt != S_FULL);
      if (w_valid && !i_ready && (r_stall != '1)) begin
        r_stall <= r_stall + 1'b1;
      end
    end
  end

  always_comb begin
    o_occupancy = 2'd0;
    unique case (r_state)
      S_EMPTY: o_occupancy = 2'd0;
      S_ONE:   o_occupancy = 2'd1;
      S_FULL:  o_occupancy = 2'd2;
      default: o_occupancy = 2'd0;
    endcase
  end

  assign o_valid        = w_valid;
  assign o_ready        = r_ready;
  assign o_data         = r_main;
  assign o_stall_cycles = r_stall;

endmodule

// File: tb/tb_pipe_elastic.sv
// Bench for pipe_elastic: directed scenarios plus random traffic against a queue model.
module tb_pipe_elastic;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_flush;
  logic        i_valid;
  logic        i_ready;
  logic [63:0] i_data;
  logic        o_ready;
  logic        o_valid;
  logic [63:0] o_data;
  logic [1:0]  o_occupancy;
  logic [15:0] o_stall_cycles;
  logic        o_ready_s;
  logic        o_valid_s;
  logic [63:0] o_data_s;
  logic [1:0]  o_occupancy_s;
  logic [1:0]  o_stall_cycles_s;

  always #5 clk = ~clk;

  pipe_elastic #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_occupancy(o_occupancy), .o_stall_cycles(o_stall_cycles)
  );

  // Narrow-counter instance shares the stimulus to exercise saturation.
  pipe_elastic #(.DATA_WIDTH(64), .CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready_s),
    .i_data(i_data), .o_valid(o_valid_s), .i_ready(i_ready), .o_data(o_data_s),
    .o_occupancy(o_occupancy_s), .o_stall_cycles(o_stall_cycles_s)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: a FIFO of held beats plus the registered ready flag.
  logic [63:0] m_q[$];
  logic        m_ready;
  int unsigned m_stall;
  int unsigned m_stall_s;
  logic        m_data_zero;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ready     = 1'b1;
    m_stall     = 0;
    m_stall_s   = 0;
    m_data_zero = 1'b1;
  endtask

  // One clock: drive inputs after negedge, compare outputs, then advance the model.
  task automatic step(input logic v, input logic [63:0] d, input logic r,
                      input logic f, input logic rs);
    logic push;
    logic pop;
    @(negedge clk);
    i_valid = v; i_data = d; i_ready = r; i_flush = f; rst = rs;
    #1;
    chk("valid", o_valid, m_q.size() != 0);
    chk("ready", o_ready, m_ready);
    chk("occupancy", o_occupancy, m_q.size());
    chk("stall", o_stall_cycles, m_stall);
    chk("stall_sat", o_stall_cycles_s, m_stall_s);
    chk("valid_s", o_valid_s, m_q.size() != 0);
    chk("ready_s", o_ready_s, m_ready);
    if (m_q.size() != 0) begin
      chk("data", o_data, m_q[0]);
      chk("data_s", o_data_s, m_q[0]);
    end else if (m_data_zero) begin
      chk("data_rst", o_data, 64'd0);
    end
    push = v && m_ready;
    pop  = (m_q.size() != 0) && r;
    if (rs) begin
      model_reset();
    end else begin
      if ((m_q.size() != 0) && !r) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall_s < 3) m_stall_s++;
      end
      if (f) begin
        m_q.delete();
      end else begin
        if (pop) void'(m_q.pop_front());
        if (push) begin
          m_q.push_back(d);
          m_data_zero = 1'b0;
        end
      end
      m_ready = (m_q.size() != 2);
    end
  endtask

  initial begin
    rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    repeat (2) @(posedge clk);
    model_reset();
    step(0, 64'h0, 0, 0, 0);

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) step(1, 64'(i), 1, 0, 0);
    repeat (3) step(0, 64'h0, 1, 0, 0);

    // Fill the skid, hold FULL, then drain.
    step(1, 64'hA, 0, 0, 0);
    step(1, 64'hB, 0, 0, 0);
    repeat (5) step(1, 64'hEE, 0, 0, 0);
    repeat (3) step(0, 64'h0, 1, 0, 0);

    // Flush while FULL with a push pending.
    step(1, 64'h11, 0, 0, 0);
    step(1, 64'h12, 0, 0, 0);
    step(1, 64'hC, 0, 1, 0);
    repeat (3) step(0, 64'h0, 1, 0, 0);

    // Flush coinciding with a pop.
    step(1, 64'h21, 0, 0, 0);
    step(1, 64'h22, 1, 1, 0);
    repeat (2) step(0, 64'h0, 1, 0, 0);

    // Reset while FULL, then one beat through.
    step(1, 64'h31, 0, 0, 0);
    step(1, 64'h32, 0, 0, 0);
    step(0, 64'h0, 0, 0, 1);
    step(1, 64'h5A5A_5A5A_A5A5_A5A5, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0);
    step(0, 64'h0, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 3) != 0), {$urandom, $urandom}, ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 99) == 0), 1'b0);
    end
    repeat (3) step(0, 64'h0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
